// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for a 5-stage MIPS pipeline: hold/flush controls for PC, IF/ID and
// ID/EX, a multi-cycle MDU structural-hazard tracker, and stall/flush event counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MDU_LAT = 32,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             id_mdu_op,
  input  logic             ex_memread,
  input  logic [4:0]       ex_wr_reg,
  input  logic             ex_branch_taken,
  input  logic             dmem_wait,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_bubble,
  output logic             idex_stall,
  output logic             idex_bubble,
  output logic             mdu_start,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {IDLE, MDU_BUSY} state_t;

  localparam logic [7:0] LAT_M1 = 8'(MDU_LAT - 1);

  state_t     state, state_n;
  logic [7:0] mdu_cnt, mdu_cnt_n;
  logic       lu, mh;

  always_comb begin
    lu = ex_memread && (ex_wr_reg != '0) &&
         ((ex_wr_reg == id_rs) || (id_uses_rt && (ex_wr_reg == id_rt)));
    mh = (state == MDU_BUSY) && id_mdu_op;
  end

  // Rows are mutually exclusive, so stall/bubble pairs can never both assert.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_bubble = 1'b0;
    idex_stall  = 1'b0;
    idex_bubble = 1'b0;
    mdu_start   = 1'b0;
    if (rst) begin
      if (dmem_wait) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_stall = 1'b1;
      end else if (ex_branch_taken) begin
        ifid_bubble = 1'b1;
        idex_bubble = 1'b1;
      end else if (lu || mh) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_bubble = 1'b1;
      end else begin
        ifid_bubble = id_jump;
        mdu_start   = id_mdu_op && (state == IDLE);
      end
    end
  end

  assign mdu_busy = (state == MDU_BUSY);

  always_comb begin
    state_n   = state;
    mdu_cnt_n = mdu_cnt;
    case (state)
      IDLE: begin
        if (mdu_start) begin
          state_n   = MDU_BUSY;
          mdu_cnt_n = LAT_M1;
        end
      end
      MDU_BUSY: begin
        if (mdu_cnt == '0) state_n = IDLE;
        else               mdu_cnt_n = mdu_cnt - 8'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      mdu_cnt     <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state   <= state_n;
      mdu_cnt <= mdu_cnt_n;
      if (pc_stall)    stall_count <= stall_count + CNT_W'(1);
      if (ifid_bubble) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table-driven bench for pipe_hazard_ctrl plus hand-written sequences for
// reset, MDU occupancy, memory wait and counter wrap.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_wr_reg;
  logic        id_uses_rt, id_jump, id_mdu_op, ex_memread, ex_branch_taken, dmem_wait;
  logic        pc_stall, ifid_stall, ifid_bubble, idex_stall, idex_bubble, mdu_start, mdu_busy;
  logic [31:0] stall_count, flush_count;
  logic        w_pc_stall, w_ifid_stall, w_ifid_bubble, w_idex_stall, w_idex_bubble;
  logic        w_mdu_start, w_mdu_busy;
  logic [3:0]  w_stall_count, w_flush_count;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MDU_LAT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .id_mdu_op(id_mdu_op), .ex_memread(ex_memread),
    .ex_wr_reg(ex_wr_reg), .ex_branch_taken(ex_branch_taken), .dmem_wait(dmem_wait),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_bubble(ifid_bubble),
    .idex_stall(idex_stall), .idex_bubble(idex_bubble), .mdu_start(mdu_start),
    .mdu_busy(mdu_busy), .stall_count(stall_count), .flush_count(flush_count)
  );

  pipe_hazard_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .id_mdu_op(id_mdu_op), .ex_memread(ex_memread),
    .ex_wr_reg(ex_wr_reg), .ex_branch_taken(ex_branch_taken), .dmem_wait(dmem_wait),
    .pc_stall(w_pc_stall), .ifid_stall(w_ifid_stall), .ifid_bubble(w_ifid_bubble),
    .idex_stall(w_idex_stall), .idex_bubble(w_idex_bubble), .mdu_start(w_mdu_start),
    .mdu_busy(w_mdu_busy), .stall_count(w_stall_count), .flush_count(w_flush_count)
  );

  // exp = {pc_stall, ifid_stall, ifid_bubble, idex_stall, idex_bubble, mdu_start}
  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       jump;
    logic       mdu_op;
    logic       memread;
    logic [4:0] wr;
    logic       br;
    logic       dwait;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[14];
  int   checks = 0;
  int   errors = 0;
  int   exp_stall, exp_flush;

  function automatic logic [5:0] ctrl();
    return {pc_stall, ifid_stall, ifid_bubble, idex_stall, idex_bubble, mdu_start};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_jump = 1'b0; id_mdu_op = 1'b0;
    ex_memread = 1'b0; ex_wr_reg = '0; ex_branch_taken = 1'b0; dmem_wait = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt; id_jump = v.jump;
    id_mdu_op = v.mdu_op; ex_memread = v.memread; ex_wr_reg = v.wr;
    ex_branch_taken = v.br; dmem_wait = v.dwait;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000000};
    tbl[1]  = '{5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 6'b110010};
    tbl[2]  = '{5'd1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 6'b110010};
    tbl[3]  = '{5'd1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 6'b000000};
    tbl[4]  = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 6'b000000};
    tbl[5]  = '{5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 6'b001010};
    tbl[6]  = '{5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 6'b110100};
    tbl[7]  = '{5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b001000};
    tbl[8]  = '{5'd2, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 6'b110010};
    tbl[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 6'b110100};
    tbl[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 6'b001010};
    tbl[11] = '{5'd8, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 6'b000000};
    tbl[12] = '{5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 6'b110010};
    tbl[13] = '{5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 6'b000000};

    // Reset held with a taken branch present: everything must stay quiet.
    rst = 1'b0;
    idle_inputs();
    ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      chk("rst_ctrl", 32'(ctrl()), 32'h0);
      chk("rst_busy", 32'(mdu_busy), 32'h0);
      chk("rst_cnt", stall_count | flush_count, 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("rel_ctrl", 32'(ctrl()), 32'(6'b001010));
    chk("rel_flush0", flush_count, 32'd0);
    @(negedge clk);
    ex_branch_taken = 1'b0;
    #2;
    chk("rel_flush1", flush_count, 32'd1);

    // Combinational priority table, all in IDLE.
    do_reset();
    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      apply(tbl[i]);
      #2;
      chk($sformatf("vec%0d", i), 32'(ctrl()), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_busy", i), 32'(mdu_busy), 32'h0);
      exp_stall += int'(tbl[i].exp[5]);
      exp_flush += int'(tbl[i].exp[3]);
    end
    @(negedge clk);
    idle_inputs();
    #2;
    chk("tbl_stall_cnt", stall_count, 32'(exp_stall));
    chk("tbl_flush_cnt", flush_count, 32'(exp_flush));

    // MDU: div issues, following mult is held for the full busy window.
    do_reset();
    @(negedge clk);
    id_mdu_op = 1'b1;
    #2;
    chk("div_start", 32'(ctrl()), 32'(6'b000001));
    chk("div_busy0", 32'(mdu_busy), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      chk($sformatf("mult_hold%0d", i), 32'(ctrl()), 32'(6'b110010));
      chk($sformatf("mult_busy%0d", i), 32'(mdu_busy), 32'h1);
    end
    @(negedge clk); #2;
    chk("mult_start", 32'(ctrl()), 32'(6'b000001));
    chk("mult_busy_off", 32'(mdu_busy), 32'h0);
    @(negedge clk);
    id_mdu_op = 1'b0;
    id_rs = 5'd3;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("add_pass%0d", i), 32'(ctrl()), 32'h0);
      chk($sformatf("add_busy%0d", i), 32'(mdu_busy), 32'h1);
      @(negedge clk);
    end
    #2;
    chk("busy_end", 32'(mdu_busy), 32'h0);
    chk("mdu_stall_cnt", stall_count, 32'd4);

    // Reset mid-busy aborts to IDLE.
    @(negedge clk);
    id_mdu_op = 1'b1;
    @(negedge clk);
    id_mdu_op = 1'b0;
    #2;
    chk("abort_pre", 32'(mdu_busy), 32'h1);
    rst = 1'b0;
    #1;
    chk("abort_busy", 32'(mdu_busy), 32'h0);
    chk("abort_start", 32'(mdu_start), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("abort_idle", 32'(mdu_busy), 32'h0);

    // Memory wait freezes over a pending jump; the jump flushes once released.
    do_reset();
    @(negedge clk);
    dmem_wait = 1'b1;
    id_jump = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("dwait%0d", i), 32'(ctrl()), 32'(6'b110100));
      @(negedge clk);
    end
    dmem_wait = 1'b0;
    #2;
    chk("jump_flush", 32'(ctrl()), 32'(6'b001000));
    @(negedge clk);
    id_jump = 1'b0;
    #2;
    chk("jump_done", 32'(ctrl()), 32'h0);
    chk("dwait_stall_cnt", stall_count, 32'd3);
    chk("dwait_flush_cnt", flush_count, 32'd1);

    // 17 load-use cycles wrap the 4-bit counter to 1.
    do_reset();
    @(negedge clk);
    ex_memread = 1'b1;
    ex_wr_reg = 5'd8;
    id_rs = 5'd8;
    repeat (17) @(negedge clk);
    idle_inputs();
    #2;
    chk("wrap_cnt4", 32'(w_stall_count), 32'd1);
    chk("wrap_cnt32", stall_count, 32'd17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit that generates the hold and flush controls for the PC, the IF/ID register and the ID/EX register of the 5-stage MIPS pipeline.
- Resolves four hazard types: load-use data hazards, taken branches (resolved in EX), jumps (resolved in ID) and data-memory wait states.
- Also tracks a multi-cycle multiply/divide unit (MDU) as a structural hazard.
- Keeps stall and flush event counters for performance debug.

Parameters:
MDU_LAT, 32, MDU busy cycles after issue (valid range 2..255)
CNT_W, 32, width of the stall and flush event counters

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-low reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
id_jump  in  1  ID holds j/jal/jr; target is resolved this cycle
id_mdu_op  in  1  ID holds mult/multu/div/divu/mfhi/mflo/mthi/mtlo
ex_memread  in  1  EX holds a load
ex_wr_reg  in  5  destination register of the EX instruction
ex_branch_taken  in  1  EX resolved a taken branch this cycle
dmem_wait  in  1  MEM stage not ready; freeze the pipeline
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID (drives its stall input)
ifid_bubble  out  1  clear IF/ID (drives its bubble input)
idex_stall  out  1  hold ID/EX
idex_bubble  out  1  clear ID/EX (insert nop)
mdu_start  out  1  one-cycle pulse: MDU op issues from ID into EX
mdu_busy  out  1  MDU busy (state == MDU_BUSY)
stall_count  out  CNT_W  cycles with pc_stall=1
flush_count  out  CNT_W  cycles with ifid_bubble=1

Behaviour:
- All control outputs are combinational from the current inputs and registered state, so the stage registers act on them at the same clock edge. The state, the MDU down-counter and the event counters are registered.
- Reset (rst=0, asynchronous): state=IDLE, MDU counter=0, stall_count=0, flush_count=0. With rst=0 every control output is 0. Reset during MDU_BUSY aborts to IDLE with no mdu_start.
- Load-use hazard: lu = ex_memread & (ex_wr_reg!=0) & ((ex_wr_reg==id_rs) | (id_uses_rt & ex_wr_reg==id_rt)).
- MDU structural hazard: mh = (state==MDU_BUSY) & id_mdu_op.
- Priority, highest first; exactly one row applies per cycle:
  1. dmem_wait=1: pc_stall=ifid_stall=idex_stall=1, all bubbles 0. The MDU counter keeps counting.
  2. ex_branch_taken=1: ifid_bubble=1, idex_bubble=1, no stalls. The redirect overrides lu and mh because the ID instruction is wrong-path.
  3. lu | mh: pc_stall=ifid_stall=1, idex_bubble=1.
  4. id_jump=1: ifid_bubble=1 only (kills the fetched delay slot; no delay-slot ISA).
  5. Otherwise all controls are 0.
- Invariant: ifid_stall and ifid_bubble are never both 1; likewise idex_stall and idex_bubble.
- mdu_start = id_mdu_op & (state==IDLE) & no row 1-3 active. mfhi/mflo/mthi/mtlo pulse it the same way.
- FSM:
  - IDLE -> MDU_BUSY on mdu_start; counter loads MDU_LAT-1.
  - MDU_BUSY: counter decrements each cycle while >0. When the counter is 0, go to IDLE at the next edge. Busy therefore lasts exactly MDU_LAT cycles after the start edge.
  - A non-MDU instruction in ID proceeds during MDU_BUSY.
  - An MDU op that arrives on the same cycle the counter is 0 still stalls that cycle and issues the following cycle from IDLE.
- Counters: increment by 1 on each clock edge where the condition held in that cycle. They wrap modulo 2^CNT_W with no saturation.
- id_rs=0 or id_rt=0 never matches (the ex_wr_reg!=0 term ensures this).

Test Plan:
1. Reset: hold rst=0 for 3 cycles with ex_branch_taken=1 -> all outputs 0, counters 0; release -> ifid_bubble=1 that cycle, flush_count=1 after the edge.
2. Load-use: ex_memread=1, ex_wr_reg=8, id_rs=8 for one cycle, then ex_memread=0 -> exactly one cycle of pc_stall=ifid_stall=idex_bubble=1, stall_count=1. Repeat with id_rt=8 and id_uses_rt=0 -> no stall.
3. Branch vs load-use: ex_branch_taken=1 together with the lu condition -> ifid_bubble=idex_bubble=1, pc_stall=0, stall_count unchanged.
4. MDU: MDU_LAT=4; div in ID -> mdu_start pulse, mdu_busy=1 for 4 cycles. A second mult in ID on the next cycle -> stalled 4 cycles, then mdu_start on the 5th. An add in ID during busy -> no stall.
5. dmem_wait=1 for 3 cycles concurrent with id_jump=1 -> pc/ifid/idex stalls for 3 cycles with no bubbles; after release -> ifid_bubble=1 for one cycle.
6. Counter wrap: CNT_W=4, 17 consecutive load-use cycles -> stall_count reads 1.
